q_step_scheduler: RTL and testbench

Q_STEP_SCHEDULER -- requirements
Module: q_step_scheduler

---
 rtl/q_step_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_q_step_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_step_scheduler.sv
// Sequences one tabular Q-learning episode on an 8x8 grid: reads Q rows, hands the
// current state to an external action selector, moves, and writes back the TD update.
module q_step_scheduler #(
    parameter int Q_WIDTH   = 32,
    parameter int MAX_STEPS = 64,
    parameter int R_GOAL    = 1024,
    parameter int R_STEP    = 1,
    parameter int A_SHIFT   = 2,
    parameter int G_SHIFT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2:0]           start_i,
    input  logic [2:0]           start_j,
    input  logic [2:0]           goal_i,
    input  logic [2:0]           goal_j,
    input  logic [15:0]          eps_init,
    input  logic [15:0]          seed,
    output logic                 q_rd_en,
    output logic [5:0]           q_rd_addr,
    input  logic [4*Q_WIDTH-1:0] q_rd_data,
    output logic                 q_wr_en,
    output logic [5:0]           q_wr_addr,
    output logic [1:0]           q_wr_action,
    output logic [Q_WIDTH-1:0]   q_wr_data,
    output logic [2:0]           sel_state_i,
    output logic [2:0]           sel_state_j,
    output logic [Q_WIDTH-1:0]   sel_q0,
    output logic [Q_WIDTH-1:0]   sel_q1,
    output logic [Q_WIDTH-1:0]   sel_q2,
    output logic [Q_WIDTH-1:0]   sel_q3,
    output logic [15:0]          sel_epsilon,
    output logic [15:0]          sel_rand,
    input  logic [1:0]           sel_action,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           cur_i,
    output logic [2:0]           cur_j,
    output logic [6:0]           ep_steps
);
    localparam int TW = Q_WIDTH + 2;
    localparam logic [6:0] MAX_S = 7'(MAX_STEPS);

    typedef enum logic [3:0] {
        IDLE, RD_CUR, CAP_CUR, SEL, MOVE, RD_NXT, CAP_NXT, WR, DONE
    } state_t;

    state_t state, state_nx;

    logic [2:0]                nxt_i, nxt_j, gl_i, gl_j, mv_i, mv_j;
    logic [3:0][Q_WIDTH-1:0]   q_cur, rd_q;
    logic [Q_WIDTH-1:0]        maxq, max4, qa, q_sat;
    logic [1:0]                act;
    logic [15:0]               eps, lfsr, lfsr_nx, eps_dec, eps_nx;
    logic [6:0]                steps_inc;
    logic                      goal_hit;
    logic signed [TW-1:0]      r_val, td, q_sum;

    assign rd_q      = q_rd_data;
    assign goal_hit  = (nxt_i == gl_i) && (nxt_j == gl_j);
    assign steps_inc = ep_steps + 7'd1;
    assign lfsr_nx   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign eps_dec   = eps - (eps >> 4);
    assign eps_nx    = (eps_dec < 16'h0100) ? 16'h0100 : eps_dec;

    // Wall moves leave the coordinate unchanged.
    always_comb begin
        mv_i = cur_i;
        mv_j = cur_j;
        case (sel_action)
            2'd0: if (cur_i != 3'd0) mv_i = cur_i - 3'd1;
            2'd1: if (cur_i != 3'd7) mv_i = cur_i + 3'd1;
            2'd2: if (cur_j != 3'd0) mv_j = cur_j - 3'd1;
            default: if (cur_j != 3'd7) mv_j = cur_j + 3'd1;
        endcase
    end

    always_comb begin
        max4 = rd_q[0];
        for (int k = 1; k < 4; k++)
            if (rd_q[k] > max4) max4 = rd_q[k];
    end

    // Widened signed arithmetic so neither the TD error nor the sum can wrap.
    always_comb begin
        qa    = q_cur[act];
        r_val = goal_hit ? TW'(R_GOAL) : TW'(-R_STEP);
        td    = r_val + $signed({2'b00, maxq}) - $signed({2'b00, maxq >> G_SHIFT})
              - $signed({2'b00, qa});
        q_sum = $signed({2'b00, qa}) + (td >>> A_SHIFT);
        if (q_sum < 0)
            q_sat = '0;
        else if (q_sum[TW-1:Q_WIDTH] != 2'b00)
            q_sat = '1;
        else
            q_sat = q_sum[Q_WIDTH-1:0];
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = RD_CUR;
                RD_CUR:  state_nx = CAP_CUR;
                CAP_CUR: state_nx = SEL;
                SEL:     state_nx = MOVE;
                MOVE:    state_nx = RD_NXT;
                RD_NXT:  state_nx = CAP_NXT;
                CAP_NXT: state_nx = WR;
                WR:      state_nx = (goal_hit || steps_inc == MAX_S) ? DONE : RD_CUR;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_i    <= '0;
            cur_j    <= '0;
            nxt_i    <= '0;
            nxt_j    <= '0;
            gl_i     <= '0;
            gl_j     <= '0;
            q_cur    <= '0;
            maxq     <= '0;
            act      <= '0;
            eps      <= '0;
            lfsr     <= 16'h0001;
            ep_steps <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    cur_i    <= start_i;
                    cur_j    <= start_j;
                    gl_i     <= goal_i;
                    gl_j     <= goal_j;
                    eps      <= eps_init;
                    lfsr     <= (seed == 16'h0000) ? 16'h0001 : seed;
                    ep_steps <= '0;
                end
                CAP_CUR: q_cur <= rd_q;
                MOVE: begin
                    act   <= sel_action;
                    nxt_i <= mv_i;
                    nxt_j <= mv_j;
                end
                CAP_NXT: maxq <= goal_hit ? '0 : max4;
                WR: if (!abort) begin
                    cur_i    <= nxt_i;
                    cur_j    <= nxt_j;
                    ep_steps <= steps_inc;
                    lfsr     <= lfsr_nx;
                end
                DONE: if (!abort) eps <= eps_nx;
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE) && !abort;
    assign q_rd_en     = (state == RD_CUR) || (state == RD_NXT);
    assign q_rd_addr   = (state == RD_NXT) ? {nxt_i, nxt_j} : {cur_i, cur_j};
    assign q_wr_en     = (state == WR);
    assign q_wr_addr   = {cur_i, cur_j};
    assign q_wr_action = act;
    assign q_wr_data   = q_sat;
    assign sel_state_i = cur_i;
    assign sel_state_j = cur_j;
    assign sel_q0      = q_cur[0];
    assign sel_q1      = q_cur[1];
    assign sel_q2      = q_cur[2];
    assign sel_q3      = q_cur[3];
    assign sel_epsilon = eps;
    assign sel_rand    = lfsr;
endmodule

// File: tb/tb_q_step_scheduler.sv
// Bench for q_step_scheduler: Q-table memory model, constant-action selector and a
// write scoreboard fed by each scenario task.
module tb_q_step_scheduler;
    localparam int QW = 32;

    logic            clk, rst_n, start, abort;
    logic [2:0]      start_i, start_j, goal_i, goal_j;
    logic [15:0]     eps_init, seed;
    logic            q_rd_en, q_wr_en;
    logic [5:0]      q_rd_addr, q_wr_addr;
    logic [4*QW-1:0] q_rd_data;
    logic [1:0]      q_wr_action, sel_action;
    logic [QW-1:0]   q_wr_data, sel_q0, sel_q1, sel_q2, sel_q3;
    logic [2:0]      sel_state_i, sel_state_j, cur_i, cur_j;
    logic [15:0]     sel_epsilon, sel_rand;
    logic            busy, done;
    logic [6:0]      ep_steps;

    q_step_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .start_i(start_i), .start_j(start_j), .goal_i(goal_i), .goal_j(goal_j),
        .eps_init(eps_init), .seed(seed),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_action(q_wr_action),
        .q_wr_data(q_wr_data),
        .sel_state_i(sel_state_i), .sel_state_j(sel_state_j),
        .sel_q0(sel_q0), .sel_q1(sel_q1), .sel_q2(sel_q2), .sel_q3(sel_q3),
        .sel_epsilon(sel_epsilon), .sel_rand(sel_rand), .sel_action(sel_action),
        .busy(busy), .done(done), .cur_i(cur_i), .cur_j(cur_j), .ep_steps(ep_steps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [5:0]    addr;
        logic [1:0]    act;
        logic [QW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Q-table model: 1-cycle read latency, row = {q3,q2,q1,q0}
    logic [QW-1:0]       qmem [64][4];
    logic                mem_clr, ld_en;
    logic [5:0]          ld_addr;
    logic [3:0][QW-1:0]  ld_row;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int r = 0; r < 64; r++)
                for (int k = 0; k < 4; k++) qmem[r][k] <= '0;
        end else if (ld_en) begin
            for (int k = 0; k < 4; k++) qmem[ld_addr][k] <= ld_row[k];
        end
        if (q_wr_en) qmem[q_wr_addr][q_wr_action] <= q_wr_data;
        if (q_rd_en)
            q_rd_data <= {qmem[q_rd_addr][3], qmem[q_rd_addr][2],
                          qmem[q_rd_addr][1], qmem[q_rd_addr][0]};
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (q_wr_en) begin
            wr_t e;
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d act=%0d data=%0d", q_wr_addr, q_wr_action, q_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({q_wr_addr, q_wr_action, q_wr_data} !== {e.addr, e.act, e.data}) begin
                    errors++;
                    $display("FAIL write got addr=%0d act=%0d data=%0d expected addr=%0d act=%0d data=%0d",
                             q_wr_addr, q_wr_action, q_wr_data, e.addr, e.act, e.data);
                end
            end
        end
    end

    function automatic logic [QW-1:0] q_model(longint qa, longint maxq, bit at_goal);
        longint r, t, v;
        r = at_goal ? 1024 : -1;
        t = r + maxq - (maxq >>> 3) - qa;
        v = qa + (t >>> 2);
        if (v < 0) v = 0;
        if (v > 64'hFFFF_FFFF) v = 64'hFFFF_FFFF;
        return v[QW-1:0];
    endfunction

    function automatic logic [15:0] lfsr_step(logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic wr_t mk_wr(int addr, int act, logic [QW-1:0] data);
        wr_t w;
        w.addr = 6'(addr);
        w.act  = 2'(act);
        w.data = data;
        return w;
    endfunction

    task automatic clear_mem();
        @(negedge clk); mem_clr = 1'b1;
        @(negedge clk); mem_clr = 1'b0;
    endtask

    task automatic load_row(int addr, logic [3:0][QW-1:0] row);
        @(negedge clk); ld_en = 1'b1; ld_addr = 6'(addr); ld_row = row;
        @(negedge clk); ld_en = 1'b0;
    endtask

    // Returns at the negedge inside RD_CUR of the first step.
    task automatic start_ep(int si, int sj, int gi, int gj, logic [15:0] e, logic [15:0] s, int a);
        @(negedge clk);
        start_i = 3'(si); start_j = 3'(sj); goal_i = 3'(gi); goal_j = 3'(gj);
        eps_init = e; seed = s; sel_action = 2'(a); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout after %0d cycles", cyc);
        end
    endtask

    task automatic wait_write(input int limit);
        int n = 0;
        while (!q_wr_en && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!q_wr_en) begin
            errors++;
            $display("FAIL write_timeout after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_clr = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_row = '0; sel_action = '0; start_i = '0; start_j = '0;
        goal_i = '0; goal_j = '0; eps_init = '0; seed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, q_rd_en, q_wr_en, cur_i, cur_j, ep_steps} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b rd=%b wr=%b cur=%0d,%0d steps=%0d expected all 0",
                     busy, done, q_rd_en, q_wr_en, cur_i, cur_j, ep_steps);
        end
        checks++;
        if (sel_epsilon !== 16'h0000 || sel_rand !== 16'h0001) begin
            errors++;
            $display("FAIL reset_regs got eps=%h rand=%h expected 0000 0001", sel_epsilon, sel_rand);
        end
        rst_n = 1'b1;
        clear_mem();
    endtask

    task automatic test_goal_step();
        int cyc, w0;
        w0 = wr_cnt;
        clear_mem();
        exp_q.push_back(mk_wr(0, 3, 32'd256));
        start_ep(0, 0, 0, 1, 16'h0000, 16'hACE1, 3);
        checks++;
        if (q_rd_en !== 1'b1 || q_rd_addr !== 6'd0) begin
            errors++;
            $display("FAIL goal_rdcur got rd=%b addr=%0d expected 1 0", q_rd_en, q_rd_addr);
        end
        // RD_CUR is cycle 1 of the episode; DONE must be cycle 8
        wait_done(20, cyc);
        checks++;
        if (cyc + 1 != 8) begin
            errors++;
            $display("FAIL goal_latency got %0d expected 8", cyc + 1);
        end
        checks++;
        if (ep_steps !== 7'd1 || cur_i !== 3'd0 || cur_j !== 3'd1) begin
            errors++;
            $display("FAIL goal_state got steps=%0d cur=%0d,%0d expected 1 0,1", ep_steps, cur_i, cur_j);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_cnt - w0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL goal_end got busy=%b writes=%0d pending=%0d expected 0 1 0", busy, wr_cnt - w0, exp_q.size());
        end
        checks++;
        if (sel_rand !== lfsr_step(16'hACE1)) begin
            errors++;
            $display("FAIL lfsr_once got %h expected %h", sel_rand, lfsr_step(16'hACE1));
        end
    endtask

    task automatic test_wall();
        clear_mem();
        exp_q.push_back(mk_wr(0, 0, 32'd0));
        start_ep(0, 0, 7, 7, 16'h0000, 16'h1234, 0);
        wait_write(20);
        @(negedge clk);
        checks++;
        if (ep_steps !== 7'd1 || cur_i !== 3'd0 || cur_j !== 3'd0 || q_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL wall got steps=%0d cur=%0d,%0d rd=%b expected 1 0,0 1", ep_steps, cur_i, cur_j, q_rd_en);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wall_abort got busy=%b pending=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_update();
        logic [3:0][QW-1:0] rc, rn;
        rc = {32'd9, 32'd8, 32'd200, 32'd7};
        rn = {32'd3000, 32'd20, 32'd500, 32'd100};
        clear_mem();
        load_row(27, rc);
        load_row(35, rn);
        exp_q.push_back(mk_wr(27, 1, q_model(200, 3000, 1'b0)));
        start_ep(3, 3, 7, 7, 16'h0000, 16'h0BEE, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({sel_q3, sel_q2, sel_q1, sel_q0} !== rc || sel_state_i !== 3'd3 || sel_state_j !== 3'd3) begin
            errors++;
            $display("FAIL sel_outputs got q=%h st=%0d,%0d expected q=%h st=3,3",
                     {sel_q3, sel_q2, sel_q1, sel_q0}, sel_state_i, sel_state_j, rc);
        end
        wait_write(20);
        @(negedge clk);
        checks++;
        if (cur_i !== 3'd4 || cur_j !== 3'd3) begin
            errors++;
            $display("FAIL update_move got cur=%0d,%0d expected 4,3", cur_i, cur_j);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL update_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_max_steps();
        int cyc, w0;
        w0 = wr_cnt;
        clear_mem();
        for (int k = 0; k < 64; k++)
            exp_q.push_back(mk_wr((k < 7) ? k : 7, 3, 32'd0));
        start_ep(0, 0, 7, 7, 16'h0000, 16'h5555, 3);
        wait_done(64 * 8 + 20, cyc);
        checks++;
        if (ep_steps !== 7'd64 || wr_cnt - w0 != 64 || cur_j !== 3'd7) begin
            errors++;
            $display("FAIL max_steps got steps=%0d writes=%0d cur_j=%0d expected 64 64 7", ep_steps, wr_cnt - w0, cur_j);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL max_steps_end got busy=%b pending=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_epsilon();
        logic [15:0] feed [3];
        logic [15:0] want [3];
        int cyc;
        feed = '{16'h8000, 16'h7800, 16'h7080};
        want = '{16'h7800, 16'h7080, 16'h6978};
        for (int n = 0; n < 3; n++) begin
            clear_mem();
            exp_q.push_back(mk_wr(0, 3, 32'd256));
            start_ep(0, 0, 0, 1, feed[n], 16'h00FF, 3);
            wait_done(20, cyc);
            @(negedge clk);
            checks++;
            if (sel_epsilon !== want[n]) begin
                errors++;
                $display("FAIL epsilon_%0d got %h expected %h", n, sel_epsilon, want[n]);
            end
        end
    endtask

    task automatic test_abort();
        int w0, d0;
        clear_mem();
        w0 = wr_cnt; d0 = done_cnt;
        start_ep(0, 0, 7, 7, 16'h4000, 16'h0777, 3);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_cnt != w0 || done_cnt != d0 || sel_epsilon !== 16'h4000) begin
            errors++;
            $display("FAIL abort_sel got busy=%b writes=%0d dones=%0d eps=%h expected 0 0 0 4000",
                     busy, wr_cnt - w0, done_cnt - d0, sel_epsilon);
        end
        exp_q.push_back(mk_wr(0, 3, 32'd0));
        start_ep(0, 0, 7, 7, 16'h4000, 16'h0777, 3);
        wait_write(20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_cnt - w0 != 1 || done_cnt != d0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_wr got busy=%b writes=%0d dones=%0d pending=%0d expected 0 1 0 0",
                     busy, wr_cnt - w0, done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc, w0;
        clear_mem();
        w0 = wr_cnt;
        start_ep(0, 0, 7, 7, 16'h2000, 16'h0F0F, 3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, q_rd_en, q_wr_en, cur_i, cur_j, ep_steps} !== '0 ||
            sel_epsilon !== 16'h0000 || sel_rand !== 16'h0001) begin
            errors++;
            $display("FAIL reset_mid got busy=%b rd=%b wr=%b cur=%0d,%0d steps=%0d eps=%h rand=%h expected reset values",
                     busy, q_rd_en, q_wr_en, cur_i, cur_j, ep_steps, sel_epsilon, sel_rand);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (wr_cnt != w0) begin
            errors++;
            $display("FAIL reset_mid_write got %0d expected 0", wr_cnt - w0);
        end
        exp_q.push_back(mk_wr(0, 3, 32'd256));
        start_ep(0, 0, 0, 1, 16'h0000, 16'h0000, 3);
        checks++;
        if (sel_rand !== 16'h0001) begin
            errors++;
            $display("FAIL seed_zero got %h expected 0001", sel_rand);
        end
        wait_done(20, cyc);
        checks++;
        if (ep_steps !== 7'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_rerun got steps=%0d pending=%0d expected 1 0", ep_steps, exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_goal_step();
        test_wall();
        test_update();
        test_max_steps();
        test_epsilon();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
